noc_flit_serializer: RTL and testbench
======================================

# noc_flit_serializer

Drain-side companion to the sized FIFO. Pops `NOCDataH` flits (128-bit data plus 16-bit byte length) from a FIFO's `PipeOut` server port and re-emits the valid bytes as narrow beats on a `PipeIn` client port. It sits between the NoC receive FIFO and narrow consumers (register bridges, 32-bit DMA ports), and trims each flit to its declared length.

## Interface
Parameters:
- `dataWidth`, 32: output beat width in bits; must be a multiple of 8 and divide 128 (legal values 8, 16, 32, 64).

Ports:
- Clock and reset:
  - One clock; reset is asynchronous and active-low.
  - `CLK` input 1: single clock; all state changes on its rising edge.
  - `nRST` input 1: asynchronous, active-low reset.
- FIFO side (this block is the `PipeOut` client):
  - `in$first` input 144: head flit, `{data[127:0], length[15:0]}`, packed `NOCDataH` order.
  - `in$first__RDY` input 1: head flit valid.
  - `in$deq__RDY` input 1: FIFO can accept a dequeue.
  - `in$deq__ENA` output 1: dequeue strobe; one pulse per flit.
- Consumer side (this block is the `PipeIn` client):
  - `out$enq$v` output `dataWidth`: beat payload.
  - `out$enq__ENA` output 1: beat strobe.
  - `out$enq__RDY` input 1: consumer can accept a beat.

## Operation
- **Definitions:**
  - `BPB = dataWidth/8` is the number of bytes per beat.
  - `len = min(length, 16)`; any length above 16 is clamped.
  - `beats = ceil(len / BPB)`, with range 0 to `128/dataWidth`.
- **State:** a 128-bit flit register, a beat index `idx`, a last-index register `lastIdx`, a latched `len`, and an FSM with states `IDLE` and `SEND`.
- **Load condition:** `load = in$first__RDY && in$deq__RDY && (state==IDLE || sendLast)`.
  - `sendLast = state==SEND && idx==lastIdx && out$enq__RDY`.
- **Dequeue:** `in$deq__ENA = load`. It is never asserted unless both RDY inputs are high.
- **On load:**
  - Capture the data and `len`; set `idx = 0`; set `lastIdx = beats-1`.
  - Next state is `SEND` if `beats>0`. Otherwise it is `IDLE`: a zero-length flit is dequeued and dropped, producing no beats.
- **In SEND:**
  - `out$enq__ENA = out$enq__RDY`.
  - `out$enq$v` = data bits `[idx*dataWidth +: dataWidth]`; word 0 is the LSBs and goes out first.
  - Bytes at positions ≥ `len` within the beat are driven as zero. This applies only to the last beat.
  - A beat is accepted when `out$enq__ENA` is high. Then `idx` increments, or the state machine completes when `idx==lastIdx`.
- **Completion:** on the last accepted beat, next state is `IDLE` unless `load` fires in the same cycle. If it fires, the new flit loads and `SEND` continues with no bubble.
- **Outside SEND:** `out$enq__ENA = 0` and `out$enq$v = 0`.
- **Stalls:** while `out$enq__RDY` is low, the state, `idx` and `out$enq$v` hold.

## Timing
- **Reset:**
  - Asserting `nRST` low immediately sets state=`IDLE`, `idx=0`, `lastIdx=0`, flit register = 0.
  - While `nRST` is low, `in$deq__ENA`, `out$enq__ENA` and `out$enq$v` are forced to 0.
  - If reset arrives mid-flit, the partial flit is discarded; the beats already sent are not retracted. The FIFO head is not re-read.
- **Latency:** a flit dequeued at cycle t produces its first beat offered at t+1.
- **Throughput:**
  - With no stalls: one beat per cycle, and `beats` cycles per flit back-to-back.
  - A zero-length flit costs one `IDLE` cycle.
- **Combinational paths:**
  - `in$deq__ENA` depends on `in$first__RDY`, `in$deq__RDY`, `out$enq__RDY` and state.
  - `out$enq__ENA` depends only on `out$enq__RDY` and state.
  - There is no path from `in$first` to any output within the same cycle.
- **Exclusivity:** at most one dequeue per cycle. `in$deq__ENA` and a non-final beat strobe are mutually exclusive.

## Structure
- **Shared package** holds:
  - The `NOCDataH` typedef.
  - `NOC_DATA_WIDTH=128` and `NOC_LEN_WIDTH=16`.
  - `NOC_MAX_BYTES=16`.
- **This block** derives `BPB`, `MAXBEATS=128/dataWidth` and index widths locally as localparams.
- **Sub-modules:** none. The FSM, the beat mux and the last-beat byte mask are small enough to stay inline.

## Test plan
- **Full flit:**
  - Stimulus: `dataWidth`=32, data=`0x33333333_22222222_11111111_00000000`, length=16, consumer always ready.
  - Required: one `in$deq__ENA` pulse, then beats 0x00000000, 0x11111111, 0x22222222, 0x33333333 on 4 consecutive cycles.
- **Partial flit:**
  - Stimulus: length=6, data low bytes `0x..._DDCCBBAA_44332211`.
  - Required: 2 beats, 0x44332211 then 0x0000BBAA.
- **Zero length and clamp:**
  - Stimulus: a length=0 flit, then a length=40 flit.
  - Required: the first is dequeued with no beats; the second emits 4 beats, treated as length 16.
- **Back-to-back and backpressure:**
  - Stimulus: three length-8 flits queued; `out$enq__RDY` low on cycles 2–4.
  - Required: 6 beats in order, no bubble between flits when ready, `out$enq$v` stable during the stall, exactly 3 dequeues.
- **Reset mid-flit:**
  - Stimulus: pull `nRST` low after beat 1 of a 4-beat flit.
  - Required: outputs go to 0 immediately; after release, the next FIFO flit starts at beat 0.
- **Width variant:**
  - Stimulus: `dataWidth`=8, length=3, data bytes 0xA1 0xB2 0xC3.
  - Required: beats 0xA1, 0xB2, 0xC3, then `IDLE`.

Source files
------------

// File: rtl/noc_flit_serializer_pkg.sv
// -----------------------------------------------------------------------------
// noc_flit_serializer_pkg
//   Shared NoC flit definitions used by the FIFO drain-side serializer.
//   - NOCDataH : packed flit, {data[127:0], length[15:0]}
//   - clamp_len: trims a declared byte length to the flit payload size
//   - ST_*     : serializer FSM encodings
// -----------------------------------------------------------------------------
package noc_flit_serializer_pkg;

    localparam int NOC_DATA_WIDTH = 128;
    localparam int NOC_LEN_WIDTH  = 16;
    localparam int NOC_MAX_BYTES  = 16;

    // Width able to hold 0..NOC_MAX_BYTES inclusive.
    localparam int NOC_CLEN_WIDTH = $clog2(NOC_MAX_BYTES + 1);

    typedef logic [NOC_CLEN_WIDTH-1:0] noc_len_t;

    typedef struct packed {
        logic [NOC_DATA_WIDTH-1:0] data;
        logic [NOC_LEN_WIDTH-1:0]  length;
    } NOCDataH;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    // Lengths beyond the payload size are treated as a full flit.
    function automatic noc_len_t clamp_len(input logic [NOC_LEN_WIDTH-1:0] length);
        if (length > NOC_LEN_WIDTH'(NOC_MAX_BYTES))
            return noc_len_t'(NOC_MAX_BYTES);
        return length[NOC_CLEN_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/noc_flit_serializer.sv
// -----------------------------------------------------------------------------
// noc_flit_serializer
//   Pops NOCDataH flits from a FIFO and re-emits their valid bytes as narrow
//   beats, LSB word first, trimming each flit to its declared length.
//
// Parameters
//   dataWidth      : beat width in bits (8, 16, 32 or 64)
// Ports
//   CLK, nRST      : clock, asynchronous active-low reset
//   in_first       : FIFO head flit {data, length}
//   in_first__RDY  : head flit valid
//   in_deq__RDY    : FIFO can accept a dequeue
//   in_deq__ENA    : dequeue strobe, one pulse per flit
//   out_enq_v      : beat payload (zero outside SEND)
//   out_enq__ENA   : beat strobe
//   out_enq__RDY   : consumer can accept a beat
// -----------------------------------------------------------------------------
module noc_flit_serializer
    import noc_flit_serializer_pkg::*;
#(
    parameter int dataWidth = 32
) (
    input  logic                                   CLK,
    input  logic                                   nRST,
    input  logic [NOC_DATA_WIDTH+NOC_LEN_WIDTH-1:0] in_first,
    input  logic                                   in_first__RDY,
    input  logic                                   in_deq__RDY,
    output logic                                   in_deq__ENA,
    output logic [dataWidth-1:0]                   out_enq_v,
    output logic                                   out_enq__ENA,
    input  logic                                   out_enq__RDY
);

    localparam int BPB      = dataWidth / 8;
    localparam int MAXBEATS = NOC_DATA_WIDTH / dataWidth;
    localparam int IDX_W    = $clog2(MAXBEATS);

    NOCDataH                   head;
    noc_len_t                  head_len;
    int                        head_beats;

    logic [0:0]                state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [IDX_W-1:0]          last_q, last_d;
    noc_len_t                  len_q, len_d;
    logic [NOC_DATA_WIDTH-1:0] data_q, data_d;

    logic                      sending;
    logic                      send_last;
    logic                      load;
    logic [dataWidth-1:0]      beat_raw;
    logic [dataWidth-1:0]      beat_masked;

    assign head     = NOCDataH'(in_first);
    assign head_len = clamp_len(head.length);

    assign sending   = (state_q == ST_SEND);
    assign send_last = sending && (idx_q == last_q) && out_enq__RDY;

    // Gated by nRST so no dequeue escapes while the block is held in reset
    // (the FSM already sits in IDLE, which would otherwise allow a load).
    assign load = nRST && in_first__RDY && in_deq__RDY && (!sending || send_last);

    assign in_deq__ENA  = load;
    assign out_enq__ENA = sending && out_enq__RDY;

    // Beat mux plus byte trim. Only the final beat can contain bytes at or
    // beyond len, so masking every beat against len is equivalent and cheaper
    // than decoding "is last" first.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // otherwise unassigned paths infer latches.
        beat_raw    = '0;
        beat_masked = '0;
        head_beats  = (int'(head_len) + BPB - 1) / BPB;
        for (int i = 0; i < MAXBEATS; i++) begin
            if (idx_q == IDX_W'(i))
                beat_raw = data_q[i*dataWidth +: dataWidth];
        end
        for (int b = 0; b < BPB; b++) begin
            if (int'(idx_q) * BPB + b < int'(len_q))
                beat_masked[b*8 +: 8] = beat_raw[b*8 +: 8];
        end
    end

    assign out_enq_v = sending ? beat_masked : '0;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        len_d   = len_q;
        data_d  = data_q;
        if (load) begin
            // Covers both the IDLE load and the no-bubble reload on the last beat.
            data_d  = head.data;
            len_d   = head_len;
            idx_d   = '0;
            last_d  = IDX_W'(head_beats - 1);
            state_d = (head_beats > 0) ? ST_SEND : ST_IDLE;
        end else if (sending && out_enq__RDY) begin
            if (idx_q == last_q)
                state_d = ST_IDLE;
            else
                idx_d = idx_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            last_q  <= '0;
            len_q   <= '0;
            // NOTE: the wide flit register is deliberately reset so a partial
            // flit cannot leak through after a mid-flit reset.
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            len_q   <= len_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_noc_flit_serializer.sv
// -----------------------------------------------------------------------------
// tb_noc_flit_serializer
//   Directed scoreboard bench. Two DUTs (32-bit and 8-bit beats) are fed from
//   bench-side FIFO models; expected beats are queued when stimulus is issued
//   and a negedge monitor pops and compares whenever a beat strobe is seen.
// -----------------------------------------------------------------------------
module tb_noc_flit_serializer;
    import noc_flit_serializer_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        deq_rdy;

    NOCDataH     head32, head8;
    logic        first_rdy32, first_rdy8;
    logic        deq_ena32, deq_ena8;
    logic [31:0] v32;
    logic [7:0]  v8;
    logic        ena32, ena8;
    logic        rdy32, rdy8;

    noc_flit_serializer #(.dataWidth(32)) dut32 (
        .CLK           (clk),
        .nRST          (rst_n),
        .in_first      (head32),
        .in_first__RDY (first_rdy32),
        .in_deq__RDY   (deq_rdy),
        .in_deq__ENA   (deq_ena32),
        .out_enq_v     (v32),
        .out_enq__ENA  (ena32),
        .out_enq__RDY  (rdy32)
    );

    noc_flit_serializer #(.dataWidth(8)) dut8 (
        .CLK           (clk),
        .nRST          (rst_n),
        .in_first      (head8),
        .in_first__RDY (first_rdy8),
        .in_deq__RDY   (deq_rdy),
        .in_deq__ENA   (deq_ena8),
        .out_enq_v     (v8),
        .out_enq__ENA  (ena8),
        .out_enq__RDY  (rdy8)
    );

    NOCDataH     fifo32[$];
    NOCDataH     fifo8[$];
    logic [31:0] exp32[$];
    logic [7:0]  exp8[$];
    int          beat_cyc32[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int deq_cnt32 = 0;
    int deq_cnt8 = 0;
    bit pop32 = 1'b0;
    bit pop8 = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic NOCDataH mk(input logic [127:0] d, input logic [15:0] l);
        NOCDataH f;
        f.data   = d;
        f.length = l;
        return f;
    endfunction

    // Monitor: samples mid-cycle, scores beats, notes dequeues for the FIFO model.
    always @(negedge clk) begin
        pop32 = deq_ena32;
        pop8  = deq_ena8;
        if (deq_ena32) deq_cnt32++;
        if (deq_ena8)  deq_cnt8++;
        if (ena32) begin
            beat_cyc32.push_back(cyc);
            if (exp32.size() == 0) check("beat32_was_expected", 64'(exp32.size() != 0), 64'd1);
            else                   check("beat32", 64'(v32), 64'(exp32.pop_front()));
        end
        if (ena8) begin
            if (exp8.size() == 0) check("beat8_was_expected", 64'(exp8.size() != 0), 64'd1);
            else                  check("beat8", 64'(v8), 64'(exp8.pop_front()));
        end
    end

    task automatic refresh();
        first_rdy32 = (fifo32.size() > 0);
        head32      = '0;
        if (fifo32.size() > 0) head32 = fifo32[0];
        first_rdy8  = (fifo8.size() > 0);
        head8       = '0;
        if (fifo8.size() > 0) head8 = fifo8[0];
    endtask

    // Advance one cycle; inputs change 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (pop32 && fifo32.size() > 0) fifo32.delete(0);
        if (pop8 && fifo8.size() > 0)   fifo8.delete(0);
        refresh();
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while ((exp32.size() != 0 || exp8.size() != 0) && n < budget) begin
            step();
            n++;
        end
        check({name, "_all_beats_seen"}, 64'(exp32.size() + exp8.size()), 64'd0);
        repeat (3) step();
        check({name, "_fifo_empty"}, 64'(fifo32.size() + fifo8.size()), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        rst_n   = 1'b0;
        deq_rdy = 1'b1;
        rdy32   = 1'b1;
        rdy8    = 1'b1;
        refresh();
        #1;
        check("rst_ena32", 64'(ena32), 64'd0);
        check("rst_v32", 64'(v32), 64'd0);
        check("rst_deq32", 64'(deq_ena32), 64'd0);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        check("idle_ena32", 64'(ena32), 64'd0);
        check("idle_deq32", 64'(deq_ena32), 64'd0);
        check("idle_v8", 64'(v8), 64'd0);

        // Full flit: four beats, LSB word first, back-to-back.
        d0 = deq_cnt32;
        beat_cyc32.delete();
        exp32.push_back(32'h00000000);
        exp32.push_back(32'h11111111);
        exp32.push_back(32'h22222222);
        exp32.push_back(32'h33333333);
        fifo32.push_back(mk(128'h33333333_22222222_11111111_00000000, 16'd16));
        refresh();
        drain("full", 20);
        check("full_deq_count", 64'(deq_cnt32 - d0), 64'd1);
        check("full_beat_count", 64'(beat_cyc32.size()), 64'd4);
        if (beat_cyc32.size() == 4)
            for (int i = 1; i < 4; i++)
                check("full_no_gap", 64'(beat_cyc32[i] - beat_cyc32[i-1]), 64'd1);

        // Partial flit: length 6 -> bytes 4,5 of the second beat survive.
        exp32.push_back(32'h44332211);
        exp32.push_back(32'h0000BBAA);
        fifo32.push_back(mk(128'hFFFFFFFF_FFFFFFFF_DDCCBBAA_44332211, 16'd6));
        refresh();
        drain("partial", 20);

        // Zero length is dropped; 40 is clamped to 16.
        d0 = deq_cnt32;
        exp32.push_back(32'hC0DE0000);
        exp32.push_back(32'hC0DE0001);
        exp32.push_back(32'hC0DE0002);
        exp32.push_back(32'hC0DE0003);
        fifo32.push_back(mk(128'h12345678_9ABCDEF0_0F1E2D3C_4B5A6978, 16'd0));
        fifo32.push_back(mk(128'hC0DE0003_C0DE0002_C0DE0001_C0DE0000, 16'd40));
        refresh();
        drain("zero_clamp", 30);
        check("zero_clamp_deq_count", 64'(deq_cnt32 - d0), 64'd2);

        // Back-to-back with a three-cycle consumer stall after the first beat.
        d0 = deq_cnt32;
        beat_cyc32.delete();
        exp32.push_back(32'hA0000000);
        exp32.push_back(32'hA0000001);
        exp32.push_back(32'hB0000000);
        exp32.push_back(32'hB0000001);
        exp32.push_back(32'hC0000000);
        exp32.push_back(32'hC0000001);
        fifo32.push_back(mk({64'h01234567_89ABCDEF, 32'hA0000001, 32'hA0000000}, 16'd8));
        fifo32.push_back(mk({64'h01234567_89ABCDEF, 32'hB0000001, 32'hB0000000}, 16'd8));
        fifo32.push_back(mk({64'h01234567_89ABCDEF, 32'hC0000001, 32'hC0000000}, 16'd8));
        refresh();
        step();  // flit A loaded
        step();  // beat A0 accepted
        rdy32 = 1'b0;
        for (int s = 0; s < 3; s++) begin
            #1;
            check("stall_v_hold", 64'(v32), 64'hA0000001);
            check("stall_ena", 64'(ena32), 64'd0);
            step();
        end
        rdy32 = 1'b1;
        drain("backpressure", 30);
        check("bp_deq_count", 64'(deq_cnt32 - d0), 64'd3);
        check("bp_beat_count", 64'(beat_cyc32.size()), 64'd6);
        if (beat_cyc32.size() == 6) begin
            check("bp_stall_gap", 64'(beat_cyc32[1] - beat_cyc32[0]), 64'd4);
            for (int i = 2; i < 6; i++)
                check("bp_no_bubble", 64'(beat_cyc32[i] - beat_cyc32[i-1]), 64'd1);
        end

        // Reset after beat 1 of a 4-beat flit; the next flit starts at beat 0.
        d0 = deq_cnt32;
        beat_cyc32.delete();
        exp32.push_back(32'hDDDD0000);
        exp32.push_back(32'hDDDD0001);
        exp32.push_back(32'hEEEE0000);
        exp32.push_back(32'h00000001);
        fifo32.push_back(mk(128'hDDDD0003_DDDD0002_DDDD0001_DDDD0000, 16'd16));
        fifo32.push_back(mk(128'hFFFFFFFF_FFFFFFFF_77665501_EEEE0000, 16'd5));
        refresh();
        for (int n = 0; n < 20 && beat_cyc32.size() < 2; n++) step();
        check("rst_mid_reached_beat1", 64'(beat_cyc32.size()), 64'd2);
        rst_n = 1'b0;
        #1;
        check("rst_mid_ena", 64'(ena32), 64'd0);
        check("rst_mid_v", 64'(v32), 64'd0);
        check("rst_mid_deq", 64'(deq_ena32), 64'd0);
        step();
        step();
        rst_n = 1'b1;
        drain("rst_mid", 20);
        check("rst_mid_deq_count", 64'(deq_cnt32 - d0), 64'd2);

        // 8-bit variant: three bytes then back to idle.
        d0 = deq_cnt8;
        exp8.push_back(8'hA1);
        exp8.push_back(8'hB2);
        exp8.push_back(8'hC3);
        fifo8.push_back(mk({{13{8'hFF}}, 8'hC3, 8'hB2, 8'hA1}, 16'd3));
        refresh();
        drain("w8", 20);
        check("w8_deq_count", 64'(deq_cnt8 - d0), 64'd1);
        check("w8_idle_ena", 64'(ena8), 64'd0);
        check("w8_idle_v", 64'(v8), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
